alu_scoreboard: RTL and testbench

- Passive on-chip checker at the output end of the 4-bit ALU.
- Snoops the same in1/in2/s/ld stimulus the ALU receives and runs a cycle-accurate shadow model of it.
- Compares the model against the ALU's registered 8-bit out every cycle, counting checks and mismatches and capturing the first failure.
- Drives nothing into the ALU; used in self-test builds and by benches as a golden monitor.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_ref_model.sv | 57 +++++
 rtl/alu_scoreboard.sv | 102 ++++++++++
 tb/tb_alu_scoreboard.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit ALU and its scoreboard: opcodes, widths and checker states.
// With ALU_SB_STOP_ON_FAIL_EN defined the checker gains a HALT state entered on the first mismatch.
package alu_pkg;

  localparam int ALU_W_IN  = 4;
  localparam int ALU_W_OUT = 8;
  localparam int SB_ERR_W  = 8;
  localparam int SB_CHK_W  = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;
  localparam logic [2:0] OP_UP   = 3'b101;
  localparam logic [2:0] OP_DOWN = 3'b110;
  localparam logic [2:0] OP_DBL  = 3'b111;

`ifdef ALU_SB_STOP_ON_FAIL_EN
  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_RUN  = 2'd1,
    SB_HALT = 2'd2
  } sb_state_t;
`else
  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_RUN  = 2'd1
  } sb_state_t;
`endif

endpackage

// File: rtl/alu_ref_model.sv
// Cycle-accurate shadow of the 4-bit ALU: exp updates on the same edge as the ALU's registered out.
// Reusable by any checker that needs the golden ALU result.
module alu_ref_model import alu_pkg::*; #(
  parameter int W_IN  = ALU_W_IN,
  parameter int W_OUT = ALU_W_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_IN-1:0]  in1,
  input  logic [W_IN-1:0]  in2,
  input  logic [2:0]       s,
  input  logic             ld,
  output logic [W_OUT-1:0] exp
);

  logic [W_OUT-1:0] exp_nxt;
  logic [W_IN-1:0]  c;
  logic [W_IN-1:0]  c_up;
  logic [W_IN-1:0]  c_dn;
  logic [W_IN-1:0]  diff;
  logic [W_IN-1:0]  dec;

  assign c    = exp[W_IN-1:0];
  assign c_up = c + W_IN'(1);
  assign c_dn = c - W_IN'(1);
  assign diff = in1 - in2;
  assign dec  = in1 - W_IN'(1);

  // Counter modes wrap c and flag the terminal value in the bit just above it
  always_comb begin
    exp_nxt = exp;
    if (ld) begin
      case (s)
        OP_ADD:  exp_nxt = W_OUT'(in1) + W_OUT'(in2);
        OP_SUB:  exp_nxt = W_OUT'(diff);
        OP_INC:  exp_nxt = W_OUT'(in1) + W_OUT'(1);
        OP_DEC:  exp_nxt = W_OUT'(dec);
        OP_CMP:  exp_nxt = W_OUT'({in1 > in2, in1 < in2, in1 == in2});
        OP_UP,
        OP_DOWN: exp_nxt = W_OUT'(in1);
        default: exp_nxt = W_OUT'({in1, 1'b0});
      endcase
    end else begin
      case (s)
        OP_UP:   exp_nxt = W_OUT'({c_up == '1, c_up});
        OP_DOWN: exp_nxt = W_OUT'({c_dn == '0, c_dn});
        default: exp_nxt = exp;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) exp <= '0;
    else     exp <= exp_nxt;
  end

endmodule

// File: rtl/alu_scoreboard.sv
// Passive ALU checker: compares the shadow model against the ALU's registered out and logs failures.
// Define ALU_SB_STOP_ON_FAIL_EN to freeze the counters in a HALT state after the first mismatch.
module alu_scoreboard import alu_pkg::*; #(
  parameter int W_IN  = ALU_W_IN,
  parameter int W_OUT = ALU_W_OUT,
  parameter int ERR_W = SB_ERR_W,
  parameter int CHK_W = SB_CHK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W_IN-1:0]  in1,
  input  logic [W_IN-1:0]  in2,
  input  logic [2:0]       s,
  input  logic             ld,
  input  logic [W_OUT-1:0] out,
  output logic [W_OUT-1:0] exp,
  output logic [CHK_W-1:0] chk_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail,
  output logic [W_OUT-1:0] ff_exp,
  output logic [W_OUT-1:0] ff_got,
  output logic [2:0]       ff_op,
  output logic             busy
);

  sb_state_t  state;
  sb_state_t  state_nxt;
  logic       vld;
  logic [2:0] s_q;
  logic       do_cmp;
  logic       mismatch;

  alu_ref_model #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT)
  ) u_ref (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .s   (s),
    .ld  (ld),
    .exp (exp)
  );

  // Both exp and out are registered, so the compare needs no extra alignment stage
  assign do_cmp   = (state == SB_RUN) && vld;
  assign mismatch = do_cmp && (exp != out);

  always_ff @(posedge clk) begin
    if (rst) state <= SB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      SB_IDLE: if (en) state_nxt = SB_RUN;
      SB_RUN: begin
        busy = 1'b1;
        if (!en) state_nxt = SB_IDLE;
`ifdef ALU_SB_STOP_ON_FAIL_EN
        if (mismatch) state_nxt = SB_HALT;
`endif
      end
`ifdef ALU_SB_STOP_ON_FAIL_EN
      SB_HALT: state_nxt = SB_HALT;
`endif
      default: state_nxt = SB_IDLE;
    endcase
  end

  // s_q is the opcode that produced the exp currently under comparison
  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= 1'b0;
      s_q     <= '0;
      chk_cnt <= '0;
      err_cnt <= '0;
      fail    <= 1'b0;
      ff_exp  <= '0;
      ff_got  <= '0;
      ff_op   <= '0;
    end else begin
      vld <= 1'b1;
      s_q <= s;
      if (do_cmp && (chk_cnt != '1)) chk_cnt <= chk_cnt + CHK_W'(1);
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        if (!fail) begin
          fail   <= 1'b1;
          ff_exp <= exp;
          ff_got <= out;
          ff_op  <= s_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_scoreboard.sv
// Directed bench for alu_scoreboard: drives ALU stimulus plus a hand-computed ALU out, checks all outputs.
// Also covers the ALU_SB_STOP_ON_FAIL_EN build when that macro is defined.
module tb_alu_scoreboard;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  in1;
  logic [3:0]  in2;
  logic [2:0]  s;
  logic        ld;
  logic [7:0]  out;
  logic [7:0]  exp;
  logic [15:0] chk_cnt;
  logic [7:0]  err_cnt;
  logic        fail;
  logic [7:0]  ff_exp;
  logic [7:0]  ff_got;
  logic [2:0]  ff_op;
  logic        busy;

  int compared;
  int mismatched;

  alu_scoreboard dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in1     (in1),
    .in2     (in2),
    .s       (s),
    .ld      (ld),
    .out     (out),
    .exp     (exp),
    .chk_cnt (chk_cnt),
    .err_cnt (err_cnt),
    .fail    (fail),
    .ff_exp  (ff_exp),
    .ff_got  (ff_got),
    .ff_op   (ff_op),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point after the next edge
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input logic l, input logic [7:0] o);
    rst = r; en = e; in1 = a; in2 = b; s = op; ld = l; out = o;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  logic [3:0] tab_a   [7] = '{4'hF, 4'h3, 4'h0, 4'hF, 4'hF, 4'h5, 4'h2};
  logic [3:0] tab_b   [7] = '{4'h0, 4'h5, 4'h0, 4'h0, 4'hF, 4'h5, 4'h9};
  logic [2:0] tab_op  [7] = '{OP_DBL, OP_SUB, OP_DEC, OP_INC, OP_ADD, OP_CMP, OP_CMP};
  logic [7:0] tab_exp [7] = '{8'h1E, 8'h0E, 8'h0F, 8'h10, 8'h1E, 8'h01, 8'h02};

  initial begin
    compared   = 0;
    mismatched = 0;

    applyStimulus(1, 0, 4'h0, 4'h0, OP_ADD, 0, 8'h00);
    applyStimulus(1, 0, 4'h0, 4'h0, OP_ADD, 0, 8'h00);
    checkOutput("rst_exp", exp, 0);
    checkOutput("rst_chk", chk_cnt, 0);
    checkOutput("rst_err", err_cnt, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ff", {ff_exp, ff_got, 5'b0, ff_op}, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, tab_a[i], tab_b[i], tab_op[i], 1, 8'h00);
      checkOutput($sformatf("op_tab%0d", i), exp, tab_exp[i]);
    end
    applyStimulus(0, 0, 4'h7, 4'h7, OP_ADD, 0, 8'h00);
    checkOutput("hold_exp", exp, 8'h02);
    checkOutput("idle_chk", chk_cnt, 0);
    checkOutput("idle_busy", busy, 0);

    applyStimulus(0, 1, 4'h2, 4'hA, OP_ADD, 1, 8'h02);
    checkOutput("add_exp", exp, 8'h0C);
    checkOutput("run_busy", busy, 1);
    checkOutput("first_chk", chk_cnt, 0);
    applyStimulus(0, 1, 4'h2, 4'hA, OP_ADD, 1, 8'h0C);
    checkOutput("add_chk1", chk_cnt, 1);
    applyStimulus(0, 1, 4'h2, 4'hA, OP_ADD, 1, 8'h0C);
    checkOutput("add_chk2", chk_cnt, 2);
    checkOutput("add_err", err_cnt, 0);
    checkOutput("add_fail", fail, 0);

    applyStimulus(0, 1, 4'hD, 4'h0, OP_UP, 1, 8'h0C);
    checkOutput("up_ld", exp, 8'h0D);
    applyStimulus(0, 1, 4'h0, 4'h0, OP_UP, 0, 8'h0D);
    checkOutput("up_1", exp, 8'h0E);
    applyStimulus(0, 1, 4'h0, 4'h0, OP_UP, 0, 8'h0E);
    checkOutput("up_2", exp, 8'h1F);
    applyStimulus(0, 1, 4'h0, 4'h0, OP_UP, 0, 8'h1F);
    checkOutput("up_3", exp, 8'h00);
    checkOutput("up_chk", chk_cnt, 6);

    applyStimulus(0, 1, 4'h2, 4'h0, OP_DOWN, 1, 8'h00);
    checkOutput("dn_ld", exp, 8'h02);
    applyStimulus(0, 1, 4'h0, 4'h0, OP_DOWN, 0, 8'h02);
    checkOutput("dn_1", exp, 8'h01);
    applyStimulus(0, 1, 4'h0, 4'h0, OP_DOWN, 0, 8'h01);
    checkOutput("dn_2", exp, 8'h10);
    applyStimulus(0, 1, 4'h0, 4'h0, OP_DOWN, 0, 8'h10);
    checkOutput("dn_3", exp, 8'h0F);
    checkOutput("dn_chk", chk_cnt, 10);
    checkOutput("dn_err", err_cnt, 0);

    applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'h0F);
    checkOutput("cmp_exp", exp, 8'h04);
    applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'h05);
    checkOutput("err1_cnt", err_cnt, 1);
    checkOutput("err1_chk", chk_cnt, 12);
    checkOutput("err1_fail", fail, 1);
    checkOutput("err1_ffexp", ff_exp, 8'h04);
    checkOutput("err1_ffgot", ff_got, 8'h05);
    checkOutput("err1_ffop", ff_op, OP_CMP);

`ifdef ALU_SB_STOP_ON_FAIL_EN
    checkOutput("halt_busy", busy, 0);
    applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'h07);
    applyStimulus(0, 0, 4'h9, 4'h2, OP_CMP, 1, 8'h07);
    applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'h07);
    checkOutput("halt_err", err_cnt, 1);
    checkOutput("halt_chk", chk_cnt, 12);
    checkOutput("halt_busy2", busy, 0);
    applyStimulus(0, 1, 4'h9, 4'h0, OP_INC, 1, 8'h07);
    checkOutput("halt_track", exp, 8'h0A);
    applyStimulus(1, 1, 4'h0, 4'h0, OP_ADD, 0, 8'h00);
    checkOutput("hrst_chk", chk_cnt, 0);
    checkOutput("hrst_err", err_cnt, 0);
    checkOutput("hrst_fail", fail, 0);
    checkOutput("hrst_busy", busy, 0);
    applyStimulus(0, 1, 4'h0, 4'h0, OP_ADD, 0, 8'h00);
    checkOutput("hrst_run", busy, 1);
`else
    applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'h07);
    checkOutput("err2_cnt", err_cnt, 2);
    checkOutput("err2_ffgot", ff_got, 8'h05);
    checkOutput("err2_ffexp", ff_exp, 8'h04);

    applyStimulus(0, 0, 4'h9, 4'h2, OP_CMP, 1, 8'h04);
    checkOutput("enfall_chk", chk_cnt, 14);
    checkOutput("enfall_busy", busy, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'h9, 4'h2, OP_CMP, 1, 8'h55);
    checkOutput("enoff_chk", chk_cnt, 14);
    checkOutput("enoff_err", err_cnt, 2);
    applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'h55);
    checkOutput("enrise_busy", busy, 1);
    checkOutput("enrise_chk", chk_cnt, 14);
    applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'h04);
    checkOutput("resume_chk", chk_cnt, 15);
    checkOutput("resume_err", err_cnt, 2);

    for (int i = 0; i < 260; i++) applyStimulus(0, 1, 4'h9, 4'h2, OP_CMP, 1, 8'hAA);
    checkOutput("sat_err", err_cnt, 8'hFF);
    checkOutput("sat_chk", chk_cnt, 275);
    checkOutput("sat_ffgot", ff_got, 8'h05);

    applyStimulus(1, 1, 4'h9, 4'h2, OP_CMP, 1, 8'hAA);
    checkOutput("mrst_exp", exp, 0);
    checkOutput("mrst_chk", chk_cnt, 0);
    checkOutput("mrst_err", err_cnt, 0);
    checkOutput("mrst_fail", fail, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_ff", {ff_exp, ff_got, 5'b0, ff_op}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
